// File: rtl/pixel_fetcher.sv
// Column pixel fetcher: on each accepted angle tick, reads one column of the
// frame RAM (colour innermost, then row) and streams it out over a valid/ready handshake.
module pixel_fetcher #(
    parameter int ROW_WIDTH   = 5,
    parameter int NB_ROWS     = 32,
    parameter int NB_ANGLES   = 128,
    parameter int DATA_WIDTH  = 8,
    localparam int ANGLE_WIDTH = $clog2(NB_ANGLES)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   angle_tick,
    input  logic                   index,
    input  logic                   clr_overrun,
    output logic [ROW_WIDTH-1:0]   row,
    output logic [ANGLE_WIDTH-1:0] angle,
    output logic [1:0]             color,
    output logic                   rd_en,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   col_done,
    output logic                   overrun
);

    // state | meaning
    // IDLE  | waiting for an angle_tick
    // READ  | rd_en high, address (row, angle, color) presented to the RAM
    // CAPT  | rd_data valid, captured into out_data
    // OUT   | out_valid high, waiting for out_ready
    typedef enum logic [1:0] {IDLE, READ, CAPT, OUT} state_t;

    localparam logic [ANGLE_WIDTH-1:0] LAST_ANGLE = ANGLE_WIDTH'(NB_ANGLES - 1);
    localparam logic [ROW_WIDTH-1:0]   LAST_ROW   = ROW_WIDTH'(NB_ROWS - 1);

    state_t                 state;
    logic [ANGLE_WIDTH-1:0] angle_cnt;
    logic [ANGLE_WIDTH-1:0] tick_angle;
    logic                   tick_ok;
    logic                   tick_lost;

    // index coinciding with a tick makes that tick use angle 0
    assign tick_angle = index ? '0 : angle_cnt;
    // the col_done cycle still counts as busy for tick acceptance
    assign tick_ok    = angle_tick && (state == IDLE) && !col_done;
    assign tick_lost  = angle_tick && !tick_ok;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            angle_cnt <= '0;
        end else if (angle_tick) begin
            angle_cnt <= (tick_angle == LAST_ANGLE) ? '0 : tick_angle + ANGLE_WIDTH'(1);
        end else if (index) begin
            angle_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            overrun <= 1'b0;
        end else if (tick_lost) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            row       <= '0;
            angle     <= '0;
            color     <= '0;
            out_data  <= '0;
            rd_en     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            col_done  <= 1'b0;
        end else begin
            col_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick_ok) begin
                        angle <= tick_angle;
                        row   <= '0;
                        color <= '0;
                        rd_en <= 1'b1;
                        busy  <= 1'b1;
                        state <= READ;
                    end
                end
                READ: begin
                    rd_en <= 1'b0;
                    state <= CAPT;
                end
                CAPT: begin
                    out_data  <= rd_data;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (color != 2'd2) begin
                            color <= color + 2'd1;
                            rd_en <= 1'b1;
                            state <= READ;
                        end else if (row != LAST_ROW) begin
                            color <= 2'd0;
                            row   <= row + ROW_WIDTH'(1);
                            rd_en <= 1'b1;
                            state <= READ;
                        end else begin
                            busy     <= 1'b0;
                            col_done <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    rd_en     <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
